// File: rtl/beat_monitor.sv
// beat_monitor: checker for the eight-phase one-hot beat bus t0..t7.
// Locks onto the t0->t7 rotation, counts machine cycles, flags bad beats.
//
// Ports:
//   clk          clock, beat lines sampled on rising edge
//   reset        asynchronous, active-low
//   t0..t7       beat lines, exactly one high when legal
//   clear        synchronous, active-high; back to HUNT, counters zeroed
//   phase        index of the high beat in the last sample (0 if not one-hot)
//   phase_valid  last sample was one-hot
//   locked       tracking the rotation
//   fault        consecutive-error limit reached; held until clear/reset
//   cycle_done   one-clock pulse on a good t7 while locked
//   cycle_cnt    completed machine cycles, wrapping
//   err_cnt      bad samples while locked, saturating at 255
module beat_monitor #(
   parameter int CNT_W     = 16,
   parameter int ERR_LIMIT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             t0,
   input  logic             t1,
   input  logic             t2,
   input  logic             t3,
   input  logic             t4,
   input  logic             t5,
   input  logic             t6,
   input  logic             t7,
   input  logic             clear,
   output logic [2:0]       phase,
   output logic             phase_valid,
   output logic             locked,
   output logic             fault,
   output logic             cycle_done,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [7:0]       err_cnt
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      LOCKED = 2'd1,
      FAULT  = 2'd2
   } state_t;

   localparam logic [7:0] LIMIT = 8'(ERR_LIMIT);

   state_t           state;
   state_t           state_n;
   logic [2:0]       expected;
   logic [2:0]       expected_n;
   logic [7:0]       bad_run;
   logic [7:0]       bad_run_n;
   logic [CNT_W-1:0] cycle_cnt_n;
   logic [7:0]       err_cnt_n;
   logic             cycle_done_n;

   logic [7:0]       beats;
   logic             onehot;
   logic [2:0]       idx;
   logic             good;
   logic [7:0]       bad_inc;

   assign beats = {t7, t6, t5, t4, t3, t2, t1, t0};

   // Non-zero with no second set bit.
   assign onehot = (beats != 8'd0) &&
                   ((beats & (beats - 8'd1)) == 8'd0);

   // Only meaningful when onehot; multi-hot samples are masked below.
   always_comb begin
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (beats[i]) begin
            idx = 3'(i);
         end
      end
   end

   assign good    = onehot && (idx == expected);
   // bad_run stays below ERR_LIMIT (<=255) in LOCKED, so no overflow.
   assign bad_inc = bad_run + 8'd1;

   always_comb begin
      state_n      = state;
      expected_n   = expected;
      bad_run_n    = bad_run;
      cycle_cnt_n  = cycle_cnt;
      err_cnt_n    = err_cnt;
      cycle_done_n = 1'b0;

      if (clear) begin
         state_n     = HUNT;
         expected_n  = 3'd0;
         bad_run_n   = 8'd0;
         cycle_cnt_n = '0;
         err_cnt_n   = 8'd0;
      end else begin
         case (state)
            HUNT: begin
               if (onehot && idx == 3'd0) begin
                  state_n    = LOCKED;
                  expected_n = 3'd1;
                  bad_run_n  = 8'd0;
               end
            end
            LOCKED: begin
               // Free-runs: the expected beat advances even on errors.
               expected_n = expected + 3'd1;
               if (good) begin
                  bad_run_n = 8'd0;
                  if (idx == 3'd7) begin
                     cycle_done_n = 1'b1;
                     cycle_cnt_n  = cycle_cnt + CNT_W'(1);
                  end
               end else begin
                  bad_run_n = bad_inc;
                  err_cnt_n = (err_cnt == 8'hFF) ? 8'hFF
                                                 : err_cnt + 8'd1;
                  if (bad_inc >= LIMIT) begin
                     state_n = FAULT;
                  end
               end
            end
            FAULT: begin
               state_n = FAULT;
            end
            default: begin
               state_n = HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= HUNT;
         expected    <= 3'd0;
         bad_run     <= 8'd0;
         cycle_cnt   <= '0;
         err_cnt     <= 8'd0;
         cycle_done  <= 1'b0;
         phase       <= 3'd0;
         phase_valid <= 1'b0;
      end else begin
         state       <= state_n;
         expected    <= expected_n;
         bad_run     <= bad_run_n;
         cycle_cnt   <= cycle_cnt_n;
         err_cnt     <= err_cnt_n;
         cycle_done  <= cycle_done_n;
         phase       <= onehot ? idx : 3'd0;
         phase_valid <= onehot;
      end
   end

   assign locked = (state == LOCKED);
   assign fault  = (state == FAULT);

endmodule

// File: tb/tb_beat_monitor.sv
// tb_beat_monitor: scoreboard bench for beat_monitor.
// Directed scenarios plus randomized rotation with injected errors.
module tb_beat_monitor;

   localparam int CW  = 2;
   localparam int LIM = 3;

   logic          clk;
   logic          reset;
   logic [7:0]    beats;
   logic          clear;
   logic [2:0]    phase;
   logic          phase_valid;
   logic          locked;
   logic          fault;
   logic          cycle_done;
   logic [CW-1:0] cycle_cnt;
   logic [7:0]    err_cnt;

   beat_monitor #(.CNT_W(CW), .ERR_LIMIT(LIM)) dut (
      .clk         (clk),
      .reset       (reset),
      .t0          (beats[0]),
      .t1          (beats[1]),
      .t2          (beats[2]),
      .t3          (beats[3]),
      .t4          (beats[4]),
      .t5          (beats[5]),
      .t6          (beats[6]),
      .t7          (beats[7]),
      .clear       (clear),
      .phase       (phase),
      .phase_valid (phase_valid),
      .locked      (locked),
      .fault       (fault),
      .cycle_done  (cycle_done),
      .cycle_cnt   (cycle_cnt),
      .err_cnt     (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int phase;
      int pv;
      int lk;
      int ft;
      int done;
      int cnt;
      int err;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   // Reference model, kept in plain integer terms.
   localparam int M_HUNT  = 0;
   localparam int M_LOCK  = 1;
   localparam int M_FAULT = 2;
   int m_mode, m_want, m_run, m_cycles, m_errs;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   task automatic model_reset();
      m_mode   = M_HUNT;
      m_want   = 0;
      m_run    = 0;
      m_cycles = 0;
      m_errs   = 0;
   endtask

   task automatic model_step(input logic [7:0] b, input logic clr);
      exp_t e;
      int   ok;
      int   pos;
      ok  = ($countones(b) == 1);
      pos = 0;
      if (ok) pos = $clog2(b);
      e.phase = pos;
      e.pv    = ok;
      e.done  = 0;
      if (clr) begin
         model_reset();
      end else if (m_mode == M_HUNT) begin
         if (ok && pos == 0) begin
            m_mode = M_LOCK;
            m_want = 1;
            m_run  = 0;
         end
      end else if (m_mode == M_LOCK) begin
         if (ok && pos == m_want) begin
            m_run = 0;
            if (pos == 7) begin
               e.done   = 1;
               m_cycles = (m_cycles + 1) % (1 << CW);
            end
         end else begin
            m_errs = (m_errs < 255) ? m_errs + 1 : 255;
            m_run++;
            if (m_run >= LIM) m_mode = M_FAULT;
         end
         m_want = (m_want + 1) % 8;
      end
      e.lk  = (m_mode == M_LOCK);
      e.ft  = (m_mode == M_FAULT);
      e.cnt = m_cycles;
      e.err = m_errs;
      q.push_back(e);
   endtask

   task automatic drive(input logic [7:0] b, input logic clr);
      @(negedge clk);
      beats = b;
      clear = clr;
      model_step(b, clr);
   endtask

   task automatic rot(input int start, input int n);
      logic [7:0] one;
      for (int i = 0; i < n; i++) begin
         one = 8'd1;
         drive(one << ((start + i) % 8), 1'b0);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_phase"}, 32'(phase), 0);
      chk({nm, "_pv"}, 32'(phase_valid), 0);
      chk({nm, "_locked"}, 32'(locked), 0);
      chk({nm, "_fault"}, 32'(fault), 0);
      chk({nm, "_done"}, 32'(cycle_done), 0);
      chk({nm, "_cnt"}, 32'(cycle_cnt), 0);
      chk({nm, "_err"}, 32'(err_cnt), 0);
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk_zero("async_reset");
      beats = 8'd0;
      clear = 1'b0;
      model_reset();
      q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Monitor: every clock with reset released, the DUT presents a result
   // for the sample just taken; compare it to the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc++;
      if (reset && q.size() > 0) begin
         e = q.pop_front();
         chk($sformatf("phase@%0d", cyc), 32'(phase), e.phase);
         chk($sformatf("pv@%0d", cyc), 32'(phase_valid), e.pv);
         chk($sformatf("locked@%0d", cyc), 32'(locked), e.lk);
         chk($sformatf("fault@%0d", cyc), 32'(fault), e.ft);
         chk($sformatf("done@%0d", cyc), 32'(cycle_done), e.done);
         chk($sformatf("cnt@%0d", cyc), 32'(cycle_cnt), e.cnt);
         chk($sformatf("err@%0d", cyc), 32'(err_cnt), e.err);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         r;
      int         nxt;
      logic [7:0] one;
      logic [7:0] b;

      reset = 1'b0;
      beats = 8'd0;
      clear = 1'b0;
      model_reset();
      #12;
      chk_zero("reset_state");
      @(negedge clk);
      reset = 1'b1;

      // Clean acquisition and three full machine cycles.
      rot(0, 24);

      // Start mid-rotation: hunt ignores t3..t7, locks on t0.
      drive(8'h08, 1'b1);
      rot(4, 4);
      rot(0, 16);

      // One multi-hot sample, then the rotation resumes.
      drive(8'h00, 1'b1);
      rot(0, 2);
      drive(8'b0010_0100, 1'b0);
      rot(3, 13);

      // Three dead samples fault; fault absorbs a legal rotation.
      drive(8'h00, 1'b1);
      rot(0, 3);
      drive(8'h00, 1'b0);
      drive(8'h00, 1'b0);
      drive(8'h00, 1'b0);
      rot(6, 16);

      // Clear coinciding with t0 lands in HUNT; next t0 locks.
      drive(8'h01, 1'b1);
      rot(1, 7);
      rot(0, 8);

      // Counter wrap: five cycles from a fresh lock.
      drive(8'h00, 1'b1);
      rot(0, 41);

      // Isolated errors never fault but saturate err_cnt.
      drive(8'h00, 1'b1);
      rot(0, 1);
      for (int i = 0; i < 300; i++) begin
         drive(8'h00, 1'b0);
         one = 8'd1;
         drive(one << ((2 * i + 2) % 8), 1'b0);
      end

      // Reset while four beats into a locked cycle.
      drive(8'h00, 1'b1);
      rot(0, 4);
      mid_reset();
      rot(0, 16);

      // Randomized rotation with injected faults and clears.
      nxt = 0;
      for (int i = 0; i < 2000; i++) begin
         r   = $urandom_range(0, 99);
         one = 8'd1;
         b   = one << nxt;
         if (r < 80) begin
            drive(b, 1'b0);
         end else if (r < 88) begin
            drive(8'($urandom), 1'b0);
         end else if (r < 94) begin
            drive(one << ((nxt + $urandom_range(1, 7)) % 8), 1'b0);
         end else if (r < 97) begin
            drive(8'h00, 1'b0);
         end else begin
            drive(b, 1'b1);
         end
         nxt = (nxt + 1) % 8;
      end

      @(posedge clk);
      @(posedge clk);
      #2;
      chk("queue_drained", 32'(q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
